// File: rtl/di_io_bus_bridge.sv
// -----------------------------------------------------------------------------
// di_io_bus_bridge
//
// Purpose:
//   di bus terminal that turns host register reads and writes into
//   MicroBlaze-style IO bus transactions. The host talks to this block through
//   the di handshake; the block acts as IO bus initiator, one transaction at a
//   time, and returns the peripheral's read data and completion status.
//
// Ports:
//   ifclk, resetb            clock (rising edge) and synchronous active-low reset
//   di_term_addr             terminal select, compared against TERM_ADDR
//   di_reg_addr, di_len      starting word address and transfer length in bytes
//   di_read_mode/_req/di_read, di_read_rdy, di_reg_datao    read handshake
//   di_write_mode/di_write, di_write_rdy, di_reg_datai      write handshake
//   di_transfer_status       bit0 timeout, bit1 mode conflict (sticky)
//   IO_Addr/Read/Write_Strobe, IO_Address, IO_Byte_Enable, IO_Write_Data
//                            IO bus request side (all registered)
//   IO_Read_Data, IO_Ready   IO bus response side
// -----------------------------------------------------------------------------
module di_io_bus_bridge #(
    parameter logic [15:0] TERM_ADDR      = 16'h0010,
    parameter int          DI_DATA_WIDTH  = 32,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic                     ifclk,
    input  logic                     resetb,
    input  logic [15:0]              di_term_addr,
    input  logic [31:0]              di_reg_addr,
    input  logic [31:0]              di_len,
    input  logic                     di_read_mode,
    input  logic                     di_read_req,
    input  logic                     di_read,
    output logic                     di_read_rdy,
    output logic [DI_DATA_WIDTH-1:0] di_reg_datao,
    input  logic                     di_write_mode,
    input  logic                     di_write,
    output logic                     di_write_rdy,
    input  logic [DI_DATA_WIDTH-1:0] di_reg_datai,
    output logic [15:0]              di_transfer_status,
    output logic                     IO_Addr_Strobe,
    output logic                     IO_Read_Strobe,
    output logic                     IO_Write_Strobe,
    output logic [31:0]              IO_Address,
    output logic [3:0]               IO_Byte_Enable,
    output logic [DI_DATA_WIDTH-1:0] IO_Write_Data,
    input  logic [DI_DATA_WIDTH-1:0] IO_Read_Data,
    input  logic                     IO_Ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_HOLD = 2'd2,
        WR_WAIT = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LIMIT = TIMEOUT_CYCLES[15:0];

    state_t                   state_q,    state_d;
    logic [27:0]              wordAddr_q, wordAddr_d;
    logic [15:0]              tmoCnt_q,   tmoCnt_d;
    logic                     modeSeen_q, modeSeen_d;
    logic                     rdRdy_q,    rdRdy_d;
    logic                     wrRdy_q,    wrRdy_d;
    logic [DI_DATA_WIDTH-1:0] datao_q,    datao_d;
    logic [1:0]               status_q,   status_d;
    logic                     addrStb_q,  addrStb_d;
    logic                     rdStb_q,    rdStb_d;
    logic                     wrStb_q,    wrStb_d;
    logic [31:0]              ioAddr_q,   ioAddr_d;
    logic [3:0]               ioBe_q,     ioBe_d;
    logic [DI_DATA_WIDTH-1:0] ioWdata_q,  ioWdata_d;

    logic        sel;
    logic        rdModeEff;
    logic        wrOk;
    logic        modeAct;
    logic        tmoHit;
    logic [3:0]  byteEn;
    logic [27:0] nextAddr;
    logic        unused_addr_bits;

    // Everything the host drives is qualified by the terminal select, so a
    // transaction aimed at another terminal never disturbs this one.
    assign sel       = (di_term_addr == TERM_ADDR);
    assign rdModeEff = sel & di_read_mode;
    assign wrOk      = sel & di_write_mode & ~di_read_mode;
    assign modeAct   = sel & (di_read_mode | di_write_mode);
    assign tmoHit    = (tmoCnt_q >= TMO_LIMIT);
    assign nextAddr  = wordAddr_q + 28'd1;

    // The IO bus is word addressed through a fixed 0xC0000000 window, so the
    // top four bits of the di address have nowhere to go.
    assign unused_addr_bits = ^di_reg_addr[31:28];

    // Byte lanes only narrow for 1- and 2-byte transfers; any other length is
    // a full word.
    always_comb begin
        if (di_len == 32'd1) begin
            byteEn = 4'h1;
        end else if (di_len == 32'd2) begin
            byteEn = 4'h3;
        end else begin
            byteEn = 4'hF;
        end
    end

    // Next-state and output logic. Strobes default low so they can never be
    // wider than one cycle, and the write-ready flag is recomputed every cycle
    // so it only shows in IDLE while a clean write mode is held.
    always_comb begin
        state_d    = state_q;
        wordAddr_d = wordAddr_q;
        tmoCnt_d   = tmoCnt_q;
        modeSeen_d = modeAct;
        rdRdy_d    = rdRdy_q;
        wrRdy_d    = 1'b0;
        datao_d    = datao_q;
        status_d   = status_q;
        addrStb_d  = 1'b0;
        rdStb_d    = 1'b0;
        wrStb_d    = 1'b0;
        ioAddr_d   = ioAddr_q;
        ioBe_d     = ioBe_q;
        ioWdata_d  = ioWdata_q;

        case (state_q)
            IDLE: begin
                rdRdy_d = 1'b0;
                if (sel && !di_read_mode && !di_write_mode) begin
                    wordAddr_d = di_reg_addr[27:0];
                end
                // Status is sticky across a whole mode session and is only
                // wiped when the host opens a new one.
                if (modeAct && !modeSeen_q) begin
                    status_d = 2'b00;
                end
                if (rdModeEff && di_read_req) begin
                    addrStb_d = 1'b1;
                    rdStb_d   = 1'b1;
                    ioAddr_d  = {2'b11, wordAddr_q, 2'b00};
                    ioBe_d    = byteEn;
                    tmoCnt_d  = 16'd0;
                    state_d   = RD_WAIT;
                end else if (wrOk && wrRdy_q && di_write) begin
                    addrStb_d = 1'b1;
                    wrStb_d   = 1'b1;
                    ioAddr_d  = {2'b11, wordAddr_q, 2'b00};
                    ioBe_d    = byteEn;
                    ioWdata_d = di_reg_datai;
                    tmoCnt_d  = 16'd0;
                    state_d   = WR_WAIT;
                end else begin
                    wrRdy_d = wrOk;
                end
            end

            RD_WAIT: begin
                tmoCnt_d = tmoCnt_q + 16'd1;
                // IO_Ready beats a timeout landing on the same cycle.
                if (IO_Ready || tmoHit) begin
                    datao_d = IO_Ready ? IO_Read_Data : '0;
                    if (!IO_Ready) begin
                        status_d[0] = 1'b1;
                    end
                    if (rdModeEff) begin
                        rdRdy_d = 1'b1;
                        state_d = RD_HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            RD_HOLD: begin
                if (sel && di_read) begin
                    wordAddr_d = nextAddr;
                    rdRdy_d    = 1'b0;
                    if (rdModeEff) begin
                        addrStb_d = 1'b1;
                        rdStb_d   = 1'b1;
                        ioAddr_d  = {2'b11, nextAddr, 2'b00};
                        ioBe_d    = byteEn;
                        tmoCnt_d  = 16'd0;
                        state_d   = RD_WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!rdModeEff) begin
                    rdRdy_d = 1'b0;
                    state_d = IDLE;
                end
            end

            WR_WAIT: begin
                tmoCnt_d = tmoCnt_q + 16'd1;
                if (IO_Ready || tmoHit) begin
                    if (!IO_Ready) begin
                        status_d[0] = 1'b1;
                    end
                    wordAddr_d = nextAddr;
                    wrRdy_d    = wrOk;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A conflicting mode request is flagged from any state; reads carry on.
        if (sel && di_read_mode && di_write_mode) begin
            status_d[1] = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset; a reset
    // mid-transfer drops straight back to IDLE with every output cleared.
    always_ff @(posedge ifclk) begin
        if (!resetb) begin
            state_q    <= IDLE;
            wordAddr_q <= '0;
            tmoCnt_q   <= '0;
            modeSeen_q <= 1'b0;
            rdRdy_q    <= 1'b0;
            wrRdy_q    <= 1'b0;
            datao_q    <= '0;
            status_q   <= '0;
            addrStb_q  <= 1'b0;
            rdStb_q    <= 1'b0;
            wrStb_q    <= 1'b0;
            ioAddr_q   <= '0;
            ioBe_q     <= '0;
            ioWdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            wordAddr_q <= wordAddr_d;
            tmoCnt_q   <= tmoCnt_d;
            modeSeen_q <= modeSeen_d;
            rdRdy_q    <= rdRdy_d;
            wrRdy_q    <= wrRdy_d;
            datao_q    <= datao_d;
            status_q   <= status_d;
            addrStb_q  <= addrStb_d;
            rdStb_q    <= rdStb_d;
            wrStb_q    <= wrStb_d;
            ioAddr_q   <= ioAddr_d;
            ioBe_q     <= ioBe_d;
            ioWdata_q  <= ioWdata_d;
        end
    end

    assign di_read_rdy        = rdRdy_q;
    assign di_reg_datao       = datao_q;
    assign di_write_rdy       = wrRdy_q;
    assign di_transfer_status = {14'd0, status_q};
    assign IO_Addr_Strobe     = addrStb_q;
    assign IO_Read_Strobe     = rdStb_q;
    assign IO_Write_Strobe    = wrStb_q;
    assign IO_Address         = ioAddr_q;
    assign IO_Byte_Enable     = ioBe_q;
    assign IO_Write_Data      = ioWdata_q;

endmodule
